scr1_pipe_sleep_ctrl: RTL and testbench
=======================================

// Module: scr1_pipe_sleep_ctrl
// PURPOSE
//  - Issues the pipeline sleep/wake requests consumed by the core clock controller.
//  - Turns a retired WFI into a drained, clock-gated pipeline.
//  - Wakes the pipeline on a pending interrupt, a debug halt request or a drain timeout.
//  - Sits between the EXU/CSR (WFI retire, irq pending), the debug unit and the clock controller.
// PARAMETERS
//  DRAIN_TIMEOUT  64  max cycles in DRAIN waiting for pipe_idle; 0 = no timeout
//  WAKE_SETTLE    2   cycles after clk_pipe_en returns high before wfi_busy drops; min 1
// PORTS
//  clk           in   1  core clock, free-running (ungated)
//  rst           in   1  reset, asynchronous, active-high
//  wfi_req       in   1  one-cycle pulse: WFI retired
//  pipe_idle     in   1  IFU/LSU have no outstanding transactions
//  irq_pending   in   1  any pending interrupt (mie/mip AND; ignores mstatus.MIE)
//  dbg_halt_req  in   1  debug halt request (level)
//  clk_pipe_en   in   1  feedback: current pipeline clock enable from the clock controller
//  sleep_pipe    out  1  sleep request to the clock controller
//  wake_pipe     out  1  wake request to the clock controller
//  wfi_busy      out  1  stall fetch/issue while WFI is in progress
//  pipe_asleep   out  1  status: pipeline clock is gated
//  wake_cause    out  2  00 none, 01 irq, 10 debug, 11 drain timeout
// BEHAVIOUR
//  - Clock and reset: one clock (clk); rst is asynchronous and active-high.
//  - All outputs are registered/state-decoded (Moore); no input->output combinational path.
//  - Reset: state RUN, counters 0, wake_cause 00, all outputs 0.
//    Reset asserted mid-operation forces RUN immediately.
//  - wake_ev = irq_pending | dbg_halt_req; cause priority: debug > irq > timeout.
//  - RUN: all outputs 0.
//    wfi_req & wake_ev -> stay RUN (WFI acts as a NOP) and latch the cause.
//    wfi_req & ~wake_ev -> DRAIN; load the drain counter.
//  - DRAIN: wfi_busy=1.
//    wake_ev -> WAKE (cause latched).
//    else pipe_idle -> SLEEP_REQ.
//    else counter reaches DRAIN_TIMEOUT-1 -> WAKE with cause 11.
//  - SLEEP_REQ: wfi_busy=1, sleep_pipe=1.
//    wake_ev -> WAKE.
//    else ~clk_pipe_en -> SLEEP.
//  - SLEEP: wfi_busy=1, pipe_asleep=1, sleep_pipe=0.
//    wake_ev -> WAKE.
//  - WAKE: wfi_busy=1, wake_pipe=1 until clk_pipe_en=1.
//    Then count WAKE_SETTLE cycles with wake_pipe=0, then -> RUN.
//    Entered from DRAIN with clk_pipe_en already 1: settle starts the next cycle.
//  - wake_ev deasserting during WAKE does not abort the wake.
//  - wfi_req outside RUN is ignored (cannot occur while stalled; the bench asserts this).
//  - wake_cause is held until the next latch event; it is cleared only by reset.
//  - The clock controller ignores sleep when wake is also high.
//    This block never drives sleep_pipe and wake_pipe together.
//  - Counter width is $clog2(max(DRAIN_TIMEOUT,WAKE_SETTLE)+1).
//    Counters saturate and never wrap.
// STRUCTURE
//  - Package scr1_sleep_pkg holds:
//    type sleep_state_e {RUN, DRAIN, SLEEP_REQ, SLEEP, WAKE};
//    type wake_cause_e (2 bits, values above);
//    the width function for the counters.
//  - Sub-module scr1_sleep_cnt: loadable saturating down-counter with a zero flag.
//    Instantiated twice (drain timeout, wake settle).
// TESTING
//  - Entry:
//    wfi_req, irq=0, pipe_idle=1 at cycle 3 -> sleep_pipe=1;
//    model clk_pipe_en drops -> pipe_asleep=1 one cycle later.
//  - Wake from irq:
//    in SLEEP, irq_pending=1 -> wake_pipe=1 the next cycle;
//    clk_pipe_en=1 -> wfi_busy drops after 2 cycles; wake_cause=01.
//  - WFI as NOP:
//    wfi_req with irq_pending=1 -> state stays RUN, wfi_busy never set, wake_cause=01.
//  - Timeout:
//    pipe_idle held 0 -> exactly 64 cycles in DRAIN -> WAKE;
//    sleep_pipe never asserted; wake_cause=11.
//  - Race: dbg_halt_req and irq_pending asserted in the same cycle as the SLEEP_REQ entry
//    -> WAKE; wake_cause=10; sleep_pipe & wake_pipe never both 1.
//  - Reset mid-SLEEP: rst asynchronously -> all outputs 0 without a clock edge;
//    after release, state is RUN and wake_cause=00.

Source files
------------

// File: rtl/scr1_sleep_pkg.sv
// Shared types and sizing helpers for the pipeline sleep controller.
package scr1_sleep_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        DRAIN     = 3'd1,
        SLEEP_REQ = 3'd2,
        SLEEP     = 3'd3,
        WAKE      = 3'd4
    } sleep_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_IRQ  = 2'b01,
        CAUSE_DBG  = 2'b10,
        CAUSE_TMO  = 2'b11
    } wake_cause_e;

    // Both counters share one width, sized for the larger of the two limits.
    function automatic int cnt_width(input int drain_timeout, input int wake_settle);
        int max_val;
        max_val = (drain_timeout > wake_settle) ? drain_timeout : wake_settle;
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/scr1_sleep_cnt.sv
// Loadable saturating down-counter; o_zero flags a count of zero.
module scr1_sleep_cnt
    import scr1_sleep_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/scr1_pipe_sleep_ctrl.sv
// WFI sleep/wake sequencer: drains the pipeline, requests clock gating and
// wakes on interrupt, debug halt or drain timeout. All outputs decode registers.
module scr1_pipe_sleep_ctrl
    import scr1_sleep_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 64,
    parameter int WAKE_SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wfi_req,
    input  logic       pipe_idle,
    input  logic       irq_pending,
    input  logic       dbg_halt_req,
    input  logic       clk_pipe_en,
    output logic       sleep_pipe,
    output logic       wake_pipe,
    output logic       wfi_busy,
    output logic       pipe_asleep,
    output logic [1:0] wake_cause
);

    localparam int            CW          = cnt_width(DRAIN_TIMEOUT, WAKE_SETTLE);
    localparam bit            TMO_EN      = (DRAIN_TIMEOUT > 0);
    localparam logic [CW-1:0] DRAIN_LOAD  = TMO_EN ? CW'(DRAIN_TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] SETTLE_LOAD = (WAKE_SETTLE > 1) ? CW'(WAKE_SETTLE - 1) : '0;

    sleep_state_e r_state;
    sleep_state_e w_state_nxt;
    wake_cause_e  r_cause;
    wake_cause_e  w_cause_nxt;
    wake_cause_e  w_ev_cause;
    logic         r_settle;
    logic         w_settle_nxt;
    logic         w_wake_ev;
    logic         w_drain_load;
    logic         w_settle_load;
    logic         w_drain_zero;
    logic         w_settle_zero;

    assign w_wake_ev  = irq_pending | dbg_halt_req;
    assign w_ev_cause = dbg_halt_req ? CAUSE_DBG : CAUSE_IRQ;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cause_nxt   = r_cause;
        w_settle_nxt  = r_settle;
        w_drain_load  = 1'b0;
        w_settle_load = 1'b0;
        case (r_state)
            RUN: begin
                if (wfi_req) begin
                    if (w_wake_ev) begin
                        w_cause_nxt = w_ev_cause;
                    end else begin
                        w_state_nxt  = DRAIN;
                        w_drain_load = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The pipe clock is still running here, so the wake can go straight to settling.
                if (w_wake_ev || (!pipe_idle && TMO_EN && w_drain_zero)) begin
                    w_state_nxt   = WAKE;
                    w_cause_nxt   = w_wake_ev ? w_ev_cause : CAUSE_TMO;
                    w_settle_nxt  = clk_pipe_en;
                    w_settle_load = clk_pipe_en;
                end else if (pipe_idle) begin
                    w_state_nxt = SLEEP_REQ;
                end
            end
            SLEEP_REQ: begin
                if (w_wake_ev) begin
                    w_state_nxt  = WAKE;
                    w_cause_nxt  = w_ev_cause;
                    w_settle_nxt = 1'b0;
                end else if (!clk_pipe_en) begin
                    w_state_nxt = SLEEP;
                end
            end
            SLEEP: begin
                if (w_wake_ev) begin
                    w_state_nxt  = WAKE;
                    w_cause_nxt  = w_ev_cause;
                    w_settle_nxt = 1'b0;
                end
            end
            WAKE: begin
                if (!r_settle) begin
                    if (clk_pipe_en) begin
                        w_settle_nxt  = 1'b1;
                        w_settle_load = 1'b1;
                    end
                end else if (w_settle_zero) begin
                    w_state_nxt  = RUN;
                    w_settle_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = RUN;
                w_settle_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RUN;
            r_cause  <= CAUSE_NONE;
            r_settle <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cause  <= w_cause_nxt;
            r_settle <= w_settle_nxt;
        end
    end

    scr1_sleep_cnt #(.W(CW)) u_drain_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_drain_load),
        .i_load_val (DRAIN_LOAD),
        .i_dec      (r_state == DRAIN),
        .o_zero     (w_drain_zero)
    );

    scr1_sleep_cnt #(.W(CW)) u_settle_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_settle_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      ((r_state == WAKE) && r_settle),
        .o_zero     (w_settle_zero)
    );

    assign sleep_pipe  = (r_state == SLEEP_REQ);
    assign wake_pipe   = (r_state == WAKE) && !r_settle;
    assign wfi_busy    = (r_state != RUN);
    assign pipe_asleep = (r_state == SLEEP);
    assign wake_cause  = r_cause;

endmodule

// File: tb/tb_scr1_pipe_sleep_ctrl.sv
// Randomized WFI episodes; expected per-episode phase lengths and cause go to a
// scoreboard queue and a monitor compares them when each episode completes.
module tb_scr1_pipe_sleep_ctrl;

    localparam int T = 64;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wfi_req = 1'b0;
    logic       pipe_idle = 1'b0;
    logic       irq_pending = 1'b0;
    logic       dbg_halt_req = 1'b0;
    logic       clk_pipe_en = 1'b1;
    logic       sleep_pipe;
    logic       wake_pipe;
    logic       wfi_busy;
    logic       pipe_asleep;
    logic [1:0] wake_cause;

    scr1_pipe_sleep_ctrl #(.DRAIN_TIMEOUT(T), .WAKE_SETTLE(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .wfi_req      (wfi_req),
        .pipe_idle    (pipe_idle),
        .irq_pending  (irq_pending),
        .dbg_halt_req (dbg_halt_req),
        .clk_pipe_en  (clk_pipe_en),
        .sleep_pipe   (sleep_pipe),
        .wake_pipe    (wake_pipe),
        .wfi_busy     (wfi_busy),
        .pipe_asleep  (pipe_asleep),
        .wake_cause   (wake_cause)
    );

    always #5 clk = ~clk;

    // Expected observation of one WFI episode, counted in cycles per output phase.
    typedef struct {
        int cause;
        int pre;
        int sreq;
        int asl;
        int wk;
        int post;
    } ep_t;

    ep_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  env_lat    = 1;
    int  env_cnt    = 0;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Clock controller stand-in: gates on sleep, ungates env_lat cycles into a wake request.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            clk_pipe_en = 1'b1;
            env_cnt     = 0;
        end else if (wake_pipe) begin
            env_cnt++;
            if (env_cnt >= env_lat) begin
                clk_pipe_en = 1'b1;
                env_cnt     = 0;
            end
        end else if (sleep_pipe) begin
            clk_pipe_en = 1'b0;
            env_cnt     = 0;
        end
    end

    int   m_pre = 0, m_sreq = 0, m_asl = 0, m_wk = 0, m_post = 0;
    logic m_prev_busy = 1'b0;
    logic m_both = 1'b0;

    task automatic mon_clear();
        m_pre = 0; m_sreq = 0; m_asl = 0; m_wk = 0; m_post = 0;
        m_both = 1'b0;
    endtask

    task automatic episode_end();
        ep_t e;
        check("episode_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wake_cause", int'(wake_cause), e.cause);
            check("drain_len", m_pre, e.pre);
            check("sleep_req_len", m_sreq, e.sreq);
            check("asleep_len", m_asl, e.asl);
            check("wake_req_len", m_wk, e.wk);
            check("settle_len", m_post, e.post);
            check("sleep_wake_overlap", int'(m_both), 0);
        end
        mon_clear();
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            mon_clear();
            m_prev_busy = 1'b0;
        end else begin
            if (sleep_pipe && wake_pipe) m_both = 1'b1;
            if (wfi_req && m_prev_busy) check("wfi_outside_run", 1, 0);
            if (wfi_busy) begin
                if (sleep_pipe)                       m_sreq++;
                else if (pipe_asleep)                 m_asl++;
                else if (wake_pipe)                   m_wk++;
                else if ((m_sreq + m_asl + m_wk) == 0) m_pre++;
                else                                  m_post++;
            end else if (m_prev_busy || wfi_req) begin
                episode_end();
            end
            m_prev_busy = wfi_busy;
        end
    end

    // d: drain cycle where pipe_idle rises (-1 never); w: drain cycle where the wake event rises.
    task automatic run_episode(input bit nop, input int d, input int w, input bit race,
                               input int e, input int src, input int lat, input bit drop_early);
        ep_t x;
        int  k;
        int  n;
        bit  s_irq;
        bit  s_dbg;
        bit  is_sleep;
        bit  is_tmo;
        s_irq   = (src & 1) != 0;
        s_dbg   = (src & 2) != 0;
        env_lat = lat;
        x = '{cause: 0, pre: 0, sreq: 0, asl: 0, wk: 0, post: 0};
        @(negedge clk);
        if (nop) begin
            irq_pending  = s_irq;
            dbg_halt_req = s_dbg;
            wfi_req      = 1'b1;
            x.cause      = s_dbg ? 2 : 1;
            exp_q.push_back(x);
            @(negedge clk);
            wfi_req      = 1'b0;
            irq_pending  = 1'b0;
            dbg_halt_req = 1'b0;
            return;
        end
        irq_pending  = 1'b0;
        dbg_halt_req = 1'b0;
        pipe_idle    = 1'b0;
        wfi_req      = 1'b1;
        // First drain cycle that decides: a wake beats idle, idle beats the timeout.
        k = T - 1;
        if (d >= 0 && d < k)  k = d;
        if (w >= 0 && w <= k) k = w;
        is_sleep = (w != k) && (d == k);
        is_tmo   = (w != k) && (d != k);
        if (is_tmo) begin
            x.cause = 3;
            x.pre   = T + S;
        end else if (!is_sleep) begin
            x.cause = s_dbg ? 2 : 1;
            x.pre   = k + 1 + S;
        end else begin
            x.cause = s_dbg ? 2 : 1;
            x.pre   = k + 1;
            x.sreq  = 1;
            x.asl   = race ? 0 : e + 1;
            x.wk    = lat;
            x.post  = S;
        end
        exp_q.push_back(x);
        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            wfi_req   = 1'b0;
            pipe_idle = (d >= 0) && (i >= d);
            if (w >= 0 && i >= w) begin
                irq_pending  = s_irq;
                dbg_halt_req = s_dbg;
            end
        end
        if (is_sleep) begin
            @(negedge clk);
            if (!race) begin
                n = 0;
                while (!pipe_asleep && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("asleep_reached", int'(pipe_asleep), 1);
                repeat (e) @(negedge clk);
            end
            irq_pending  = s_irq;
            dbg_halt_req = s_dbg;
        end
        if (drop_early && !is_tmo) begin
            @(negedge clk);
            irq_pending  = 1'b0;
            dbg_halt_req = 1'b0;
        end
        n = 0;
        while (wfi_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("busy_release", int'(wfi_busy), 0);
        irq_pending  = 1'b0;
        dbg_halt_req = 1'b0;
        pipe_idle    = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        #2000000;
        mismatched++;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("reset_outputs_held", int'({sleep_pipe, wake_pipe, wfi_busy, pipe_asleep, wake_cause}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs_released", int'({sleep_pipe, wake_pipe, wfi_busy, pipe_asleep, wake_cause}), 0);

        run_episode(0, 0, -1, 0, 2, 1, 1, 0);   // drain, sleep, irq wake
        run_episode(1, 0, 0, 0, 0, 1, 1, 0);    // WFI as NOP under pending irq
        run_episode(0, -1, -1, 0, 0, 1, 1, 0);  // drain timeout
        run_episode(0, 3, -1, 1, 0, 3, 2, 0);   // debug+irq race at sleep-request entry
        run_episode(0, -1, 5, 0, 0, 2, 1, 1);   // debug wake while draining, dropped early
        run_episode(0, 7, 7, 0, 0, 1, 1, 0);    // wake and idle tie in the same drain cycle

        for (int r = 0; r < 40; r++) begin
            run_episode(($urandom_range(0, 5) == 0),
                        ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 40)),
                        ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 40)),
                        1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 3)),
                        int'($urandom_range(1, 3)),
                        int'($urandom_range(1, 4)),
                        1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while asleep.
        @(negedge clk);
        wfi_req   = 1'b1;
        pipe_idle = 1'b1;
        @(negedge clk);
        wfi_req = 1'b0;
        n = 0;
        while (!pipe_asleep && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("asleep_before_reset", int'(pipe_asleep), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", int'({sleep_pipe, wake_pipe, wfi_busy, pipe_asleep, wake_cause}), 0);
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        pipe_idle = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", int'({sleep_pipe, wake_pipe, wfi_busy, pipe_asleep, wake_cause}), 0);
        run_episode(1, 0, 0, 0, 0, 1, 1, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
